// File: rtl/gpu_wb_pkg.sv
// Shared definitions for the writeback commit path: flag bit positions,
// saturation constants and the commit FSM encoding.
package gpu_wb_pkg;

  localparam int NUM_LANES = 4;
  localparam int FLAG_W    = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] SAT_ONE  = 32'h3F80_0000;
  localparam logic [31:0] SAT_ZERO = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_saturate.sv
// Single-lane clamp of an IEEE single value to [0.0, 1.0]; NaNs and any
// value with the sign bit set collapse to zero.
module wb_saturate
  import gpu_wb_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 sat,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout
);

  localparam logic [DataWidth-1:0] ONE  = DataWidth'(SAT_ONE);
  localparam logic [DataWidth-1:0] ZERO = DataWidth'(SAT_ZERO);

  logic is_neg;
  logic is_nan;

  assign is_neg = din[DataWidth-1];
  assign is_nan = (&din[30:23]) & (|din[22:0]);

  // NaN must be caught before the magnitude compare, or it would clamp to one
  always_comb begin
    dout = din;
    if (sat) begin
      if (is_neg || is_nan) begin
        dout = ZERO;
      end else if (din > ONE) begin
        dout = ONE;
      end
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: saturates EX results, queues bundles and presents
// them to the shared register-file write port with a request/grant handshake.
module wb_commit_unit
  import gpu_wb_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int TotalNumBank = 8,
  parameter int AddrWidth    = 5,
  parameter int QueueDepth   = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sclr,
  input  logic                    in_valid,
  input  logic                    in_sat,
  input  logic [3:0]              in_mask,
  input  logic [TotalNumBank-1:0] in_bank_we,
  input  logic [AddrWidth-1:0]    in_addr,
  input  logic [DataWidth-1:0]    in_res0,
  input  logic [DataWidth-1:0]    in_res1,
  input  logic [DataWidth-1:0]    in_res2,
  input  logic [DataWidth-1:0]    in_res3,
  input  logic [4:0]              in_flags0,
  input  logic [4:0]              in_flags1,
  input  logic [4:0]              in_flags2,
  input  logic [4:0]              in_flags3,
  output logic                    in_full,
  output logic                    rf_req,
  input  logic                    rf_grant,
  output logic [TotalNumBank-1:0] rf_bank_we,
  output logic [AddrWidth-1:0]    rf_addr,
  output logic [3:0]              rf_lane_we,
  output logic [DataWidth-1:0]    rf_data0,
  output logic [DataWidth-1:0]    rf_data1,
  output logic [DataWidth-1:0]    rf_data2,
  output logic [DataWidth-1:0]    rf_data3,
  input  logic                    flags_clr,
  output logic [4:0]              sticky_flags,
  output logic                    ovf_err,
  output logic                    busy
);

  localparam int PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DEPTH_C = CntW'(QueueDepth);

  logic [DataWidth-1:0]    lane_res [NUM_LANES];
  logic [DataWidth-1:0]    lane_sat [NUM_LANES];
  logic [FLAG_W-1:0]       lane_flags [NUM_LANES];

  logic [TotalNumBank-1:0] q_bank_we [QueueDepth];
  logic [AddrWidth-1:0]    q_addr    [QueueDepth];
  logic [3:0]              q_mask    [QueueDepth];
  logic [DataWidth-1:0]    q_data    [QueueDepth][NUM_LANES];

  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_nxt;
  logic [FLAG_W-1:0] bundle_flags;
  logic              accept;
  logic              commit;
  logic              enq;
  logic              drop;
  wb_state_e         state;

  assign lane_res[0]   = in_res0;
  assign lane_res[1]   = in_res1;
  assign lane_res[2]   = in_res2;
  assign lane_res[3]   = in_res3;
  assign lane_flags[0] = in_flags0;
  assign lane_flags[1] = in_flags1;
  assign lane_flags[2] = in_flags2;
  assign lane_flags[3] = in_flags3;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    wb_saturate #(
      .DataWidth(DataWidth)
    ) u_sat (
      .sat (in_sat),
      .din (lane_res[g]),
      .dout(lane_sat[g])
    );
  end

  // sclr overrides both sides of the queue, so a grant in that cycle is not a commit
  always_comb begin
    accept    = in_valid & (|in_mask) & (|in_bank_we);
    commit    = rf_req & rf_grant & ~sclr;
    enq       = accept & ~sclr & ((count < DEPTH_C) | commit);
    drop      = accept & ~sclr & (count == DEPTH_C) & ~commit;
    count_nxt = count + CntW'(enq) - CntW'(commit);
    bundle_flags = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_mask[i]) begin
        bundle_flags = bundle_flags | lane_flags[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < QueueDepth; e++) begin
        q_bank_we[e] <= '0;
        q_addr[e]    <= '0;
        q_mask[e]    <= '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          q_data[e][l] <= '0;
        end
      end
    end else if (enq) begin
      q_bank_we[wr_ptr] <= in_bank_we;
      q_addr[wr_ptr]    <= in_addr;
      q_mask[wr_ptr]    <= in_mask;
      for (int l = 0; l < NUM_LANES; l++) begin
        q_data[wr_ptr][l] <= lane_sat[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      busy    <= 1'b0;
      in_full <= 1'b0;
    end else if (sclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      busy    <= 1'b0;
      in_full <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PtrW'(enq);
      rd_ptr  <= rd_ptr + PtrW'(commit);
      count   <= count_nxt;
      busy    <= (count_nxt != '0);
      in_full <= (count_nxt == DEPTH_C);
    end
  end

  // Request stays up across back-to-back commits while entries remain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else if (sclr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (count_nxt != '0) state <= REQ;
        REQ:  if (commit && (count_nxt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_req     = (state == REQ);
  assign rf_bank_we = q_bank_we[rd_ptr];
  assign rf_addr    = q_addr[rd_ptr];
  assign rf_lane_we = q_mask[rd_ptr];
  assign rf_data0   = q_data[rd_ptr][0];
  assign rf_data1   = q_data[rd_ptr][1];
  assign rf_data2   = q_data[rd_ptr][2];
  assign rf_data3   = q_data[rd_ptr][3];

  // A clear coinciding with an enqueue leaves exactly the new bundle's flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (flags_clr ? '0 : sticky_flags) | (enq ? bundle_flags : '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
    end else if (sclr) begin
      ovf_err <= 1'b0;
    end else if (drop) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: a cycle model predicts queue occupancy,
// handshake, flags and committed payloads from the driven stimulus.
module tb_wb_commit_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [7:0]  bank_we;
    logic [4:0]  addr;
    logic [3:0]  mask;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
  } entry_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sclr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sat = 1'b0;
  logic [3:0]  in_mask = '0;
  logic [7:0]  in_bank_we = '0;
  logic [4:0]  in_addr = '0;
  logic [31:0] in_res0 = '0, in_res1 = '0, in_res2 = '0, in_res3 = '0;
  logic [4:0]  in_flags0 = '0, in_flags1 = '0, in_flags2 = '0, in_flags3 = '0;
  logic        rf_grant = 1'b0;
  logic        flags_clr = 1'b0;
  logic        in_full, rf_req, ovf_err, busy;
  logic [7:0]  rf_bank_we;
  logic [4:0]  rf_addr;
  logic [3:0]  rf_lane_we;
  logic [31:0] rf_data0, rf_data1, rf_data2, rf_data3;
  logic [4:0]  sticky_flags;

  int checks = 0;
  int errors = 0;

  entry_t     sb[$];
  int         m_count = 0;
  logic [4:0] m_sticky = '0;
  logic       m_ovf = 1'b0;
  int         m_commits = 0;
  entry_t     head;
  entry_t     newe;
  logic       acc, m_commit, m_enq;
  logic [4:0] m_bflags;

  always #5 clk = ~clk;

  wb_commit_unit #(
    .DataWidth(32), .TotalNumBank(8), .AddrWidth(5), .QueueDepth(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .sclr(sclr),
    .in_valid(in_valid), .in_sat(in_sat), .in_mask(in_mask),
    .in_bank_we(in_bank_we), .in_addr(in_addr),
    .in_res0(in_res0), .in_res1(in_res1), .in_res2(in_res2), .in_res3(in_res3),
    .in_flags0(in_flags0), .in_flags1(in_flags1),
    .in_flags2(in_flags2), .in_flags3(in_flags3),
    .in_full(in_full), .rf_req(rf_req), .rf_grant(rf_grant),
    .rf_bank_we(rf_bank_we), .rf_addr(rf_addr), .rf_lane_we(rf_lane_we),
    .rf_data0(rf_data0), .rf_data1(rf_data1),
    .rf_data2(rf_data2), .rf_data3(rf_data3),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags),
    .ovf_err(ovf_err), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] satModel(input logic sat, input logic [31:0] x);
    if (!sat) return x;
    if (x[31]) return 32'h0;
    if (x[30:23] == 8'hFF && x[22:0] != 23'h0) return 32'h0;
    if (x > 32'h3F80_0000) return 32'h3F80_0000;
    return x;
  endfunction

  // Cycle model: check outputs against current model state, then advance it
  // with the inputs that the coming rising edge will see.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      m_count  = 0;
      m_sticky = '0;
      m_ovf    = 1'b0;
    end else begin
      checkOutput("rf_req", 32'(rf_req), 32'(m_count != 0));
      checkOutput("busy", 32'(busy), 32'(m_count != 0));
      checkOutput("in_full", 32'(in_full), 32'(m_count == DEPTH));
      checkOutput("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
      checkOutput("ovf_err", 32'(ovf_err), 32'(m_ovf));
      if (m_count != 0 && sb.size() != 0) begin
        head = sb[0];
        checkOutput("rf_bank_we", 32'(rf_bank_we), 32'(head.bank_we));
        checkOutput("rf_addr", 32'(rf_addr), 32'(head.addr));
        checkOutput("rf_lane_we", 32'(rf_lane_we), 32'(head.mask));
        checkOutput("rf_data0", rf_data0, head.d0);
        checkOutput("rf_data1", rf_data1, head.d1);
        checkOutput("rf_data2", rf_data2, head.d2);
        checkOutput("rf_data3", rf_data3, head.d3);
      end
      acc      = in_valid && (in_mask != 0) && (in_bank_we != 0);
      m_commit = (m_count != 0) && rf_grant && !sclr;
      m_enq    = acc && !sclr && ((m_count < DEPTH) || m_commit);
      m_bflags = (in_mask[0] ? in_flags0 : 5'b0) | (in_mask[1] ? in_flags1 : 5'b0) |
                 (in_mask[2] ? in_flags2 : 5'b0) | (in_mask[3] ? in_flags3 : 5'b0);
      if (sclr) begin
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        if (flags_clr) m_sticky = '0;
      end else begin
        if (m_commit) begin
          void'(sb.pop_front());
          m_count--;
          m_commits++;
        end
        if (m_enq) begin
          newe.bank_we = in_bank_we;
          newe.addr    = in_addr;
          newe.mask    = in_mask;
          newe.d0      = satModel(in_sat, in_res0);
          newe.d1      = satModel(in_sat, in_res1);
          newe.d2      = satModel(in_sat, in_res2);
          newe.d3      = satModel(in_sat, in_res3);
          sb.push_back(newe);
          m_count++;
        end
        if (acc && !m_enq) m_ovf = 1'b1;
        m_sticky = (flags_clr ? 5'b0 : m_sticky) | (m_enq ? m_bflags : 5'b0);
      end
    end
  end

  task automatic applyStimulus(input logic sat, input logic [3:0] mask,
                               input logic [7:0] bwe, input logic [4:0] addr,
                               input logic [31:0] r0, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] r3,
                               input logic [4:0] f0, input logic [4:0] f1,
                               input logic [4:0] f2, input logic [4:0] f3);
    @(posedge clk);
    #1;
    sclr = 1'b0;
    flags_clr = 1'b0;
    in_valid = 1'b1;
    in_sat = sat;
    in_mask = mask;
    in_bank_we = bwe;
    in_addr = addr;
    in_res0 = r0; in_res1 = r1; in_res2 = r2; in_res3 = r3;
    in_flags0 = f0; in_flags1 = f1; in_flags2 = f2; in_flags3 = f3;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sclr = 1'b0;
      flags_clr = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic drainQueue();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sclr = 1'b0;
    flags_clr = 1'b0;
    rf_grant = 1'b1;
    while (m_count != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_timeout", 32'(m_count), 32'd0);
  endtask

  initial begin
    int c0;
    #2;
    checkOutput("reset_rf_req", 32'(rf_req), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_full", 32'(in_full), 32'd0);
    checkOutput("reset_rf_data0", rf_data0, 32'd0);
    checkOutput("reset_rf_bank_we", 32'(rf_bank_we), 32'd0);
    checkOutput("reset_sticky", 32'(sticky_flags), 32'd0);
    checkOutput("reset_ovf", 32'(ovf_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single bundle, grant tied high
    rf_grant = 1'b1;
    applyStimulus(1'b0, 4'b1111, 8'h01, 5'd3, 32'h1111_1111, 32'h2222_2222,
                  32'h3333_3333, 32'h4444_4444, 5'd0, 5'd0, 5'd0, 5'd0);
    idleCycles(1);
    @(negedge clk);
    checkOutput("single_rf_req", 32'(rf_req), 32'd1);
    checkOutput("single_rf_data3", rf_data3, 32'h4444_4444);
    checkOutput("single_rf_addr", 32'(rf_addr), 32'd3);
    idleCycles(1);
    @(negedge clk);
    checkOutput("single_busy_fall", 32'(busy), 32'd0);

    // Saturation of the four spec vectors
    applyStimulus(1'b1, 4'b1111, 8'h02, 5'd7, 32'hBF80_0000, 32'h7FC0_0000,
                  32'h4000_0000, 32'h3F00_0000, 5'd0, 5'd0, 5'd0, 5'd0);
    idleCycles(1);
    @(negedge clk);
    checkOutput("sat_lane0", rf_data0, 32'h0);
    checkOutput("sat_lane1", rf_data1, 32'h0);
    checkOutput("sat_lane2", rf_data2, 32'h3F80_0000);
    checkOutput("sat_lane3", rf_data3, 32'h3F00_0000);
    idleCycles(2);

    // Backpressure: third bundle dropped
    rf_grant = 1'b0;
    applyStimulus(1'b0, 4'b0001, 8'h04, 5'd10, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 4'b0010, 8'h08, 5'd11, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 4'b0100, 8'h10, 5'd12, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("bp_in_full", 32'(in_full), 32'd1);
    idleCycles(1);
    @(negedge clk);
    checkOutput("bp_ovf_err", 32'(ovf_err), 32'd1);
    checkOutput("bp_head_addr", 32'(rf_addr), 32'd10);
    drainQueue();

    // Full queue with simultaneous commit and enqueue
    rf_grant = 1'b0;
    c0 = m_commits;
    applyStimulus(1'b0, 4'b1000, 8'h20, 5'd20, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 4'b1001, 8'h40, 5'd21, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 4'b0110, 8'h80, 5'd22, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 5'd0, 5'd0, 5'd0, 5'd0);
    rf_grant = 1'b1;
    idleCycles(1);
    @(negedge clk);
    checkOutput("fc_in_full", 32'(in_full), 32'd1);
    checkOutput("fc_head_addr", 32'(rf_addr), 32'd21);
    drainQueue();
    checkOutput("fc_commit_count", 32'(m_commits - c0), 32'd3);

    // Sticky flags: only masked lanes, then clear-with-enqueue
    applyStimulus(1'b0, 4'b0010, 8'h01, 5'd1, 32'h5, 32'h6, 32'h7, 32'h8,
                  5'b00000, 5'b00100, 5'b00001, 5'b00000);
    idleCycles(1);
    @(negedge clk);
    checkOutput("flags_masked", 32'(sticky_flags), 32'b00100);
    applyStimulus(1'b0, 4'b0001, 8'h01, 5'd2, 32'h9, 32'hA, 32'hB, 32'hC,
                  5'b10000, 5'b00000, 5'b00000, 5'b00000);
    flags_clr = 1'b1;
    idleCycles(1);
    @(negedge clk);
    checkOutput("flags_clr_enq", 32'(sticky_flags), 32'b10000);

    // Discarded bundles: zero mask, zero bank enables
    applyStimulus(1'b0, 4'b0000, 8'h01, 5'd4, 32'h1, 32'h2, 32'h3, 32'h4,
                  5'b01111, 5'b01111, 5'b01111, 5'b01111);
    applyStimulus(1'b0, 4'b1111, 8'h00, 5'd4, 32'h1, 32'h2, 32'h3, 32'h4,
                  5'b01111, 5'b01111, 5'b01111, 5'b01111);
    idleCycles(1);
    @(negedge clk);
    checkOutput("discard_busy", 32'(busy), 32'd0);
    checkOutput("discard_flags", 32'(sticky_flags), 32'b10000);

    // sclr while requesting, with grant high in the same cycle
    rf_grant = 1'b0;
    applyStimulus(1'b0, 4'b1111, 8'h03, 5'd9, 32'h77, 32'h78, 32'h79, 32'h7A, 5'd0, 5'd0, 5'd0, 5'd0);
    idleCycles(1);
    @(negedge clk);
    checkOutput("sclr_pre_req", 32'(rf_req), 32'd1);
    checkOutput("sclr_pre_ovf", 32'(ovf_err), 32'd1);
    c0 = m_commits;
    idleCycles(1);
    sclr = 1'b1;
    rf_grant = 1'b1;
    idleCycles(1);
    @(negedge clk);
    checkOutput("sclr_rf_req", 32'(rf_req), 32'd0);
    checkOutput("sclr_busy", 32'(busy), 32'd0);
    checkOutput("sclr_ovf", 32'(ovf_err), 32'd0);
    checkOutput("sclr_sticky", 32'(sticky_flags), 32'b10000);
    checkOutput("sclr_no_commit", 32'(m_commits - c0), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      sclr       = ($urandom_range(0, 29) == 0);
      flags_clr  = ($urandom_range(0, 9) == 0);
      rf_grant   = $urandom_range(0, 1) == 1;
      in_valid   = $urandom_range(0, 3) != 0;
      in_sat     = $urandom_range(0, 1) == 1;
      in_mask    = 4'($urandom);
      in_bank_we = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_addr    = 5'($urandom);
      in_res0    = $urandom;
      in_res1    = ($urandom_range(0, 1) == 1) ? 32'h7F80_0000 : 32'h3F80_0000;
      in_res2    = ($urandom_range(0, 1) == 1) ? 32'hFFC0_0001 : 32'h3F80_0001;
      in_res3    = $urandom;
      in_flags0  = 5'($urandom);
      in_flags1  = 5'($urandom);
      in_flags2  = 5'($urandom);
      in_flags3  = 5'($urandom);
    end
    drainQueue();

    // Asynchronous reset while a request is pending
    rf_grant = 1'b0;
    applyStimulus(1'b0, 4'b1111, 8'h01, 5'd5, 32'h55, 32'h56, 32'h57, 32'h58,
                  5'b00010, 5'd0, 5'd0, 5'd0);
    idleCycles(1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("areset_rf_req", 32'(rf_req), 32'd0);
    checkOutput("areset_busy", 32'(busy), 32'd0);
    checkOutput("areset_sticky", 32'(sticky_flags), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idleCycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Writeback commit unit at the consumer end of the EX/WB pipeline register. Takes each registered EX result bundle (four lane results, lane mask, bank write enables, destination address, saturate flag, lane flags), applies the saturate modifier, and buffers the bundle in a small queue. It then presents bundles to the banked register-file write port through a request/grant handshake, because the port is shared with other write sources. It also accumulates sticky exception flags for the control/status block.

## Interface
- DataWidth, 32, lane result width (IEEE single when saturating)
- TotalNumBank, 8, register-file banks, one write enable each
- AddrWidth, 5, register address width within a bank
- QueueDepth, 2, commit queue entries (power of two, ≥2)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- sclr  in  1  synchronous flush (queue, FSM, ovf_err)
- in_valid  in  1  bundle valid (EX register pipe output)
- in_sat  in  1  saturate destination
- in_mask  in  4  lane write mask
- in_bank_we  in  TotalNumBank  bank write enables
- in_addr  in  AddrWidth  destination address
- in_res0..in_res3  in  DataWidth each  lane results
- in_flags0..in_flags3  in  5 each  lane flags {NV,DZ,OF,UF,NX}
- in_full  out  1  registered, queue holds QueueDepth entries; issue logic must not issue
- rf_req  out  1  write request to register file
- rf_grant  in  1  write granted this cycle
- rf_bank_we  out  TotalNumBank  bank enables of head entry
- rf_addr  out  AddrWidth  address of head entry
- rf_lane_we  out  4  lane mask of head entry
- rf_data0..rf_data3  out  DataWidth each  (saturated) lane data
- flags_clr  in  1  clear sticky flags
- sticky_flags  out  5  accumulated flags
- ovf_err  out  1  sticky, bundle dropped due to full queue
- busy  out  1  queue non-empty

## Operation
- Accept condition: in_valid & |in_mask & |in_bank_we. Bundles failing it are discarded silently: no enqueue, no flag update.
- Saturate is applied before storage, per lane, when in_sat=1.
  - Sign bit set (including −0, negative NaN) → 0x00000000.
  - Positive NaN → 0x00000000.
  - Value > 0x3F800000 (unsigned compare, +Inf included) → 0x3F800000.
  - Otherwise unchanged.
  - When in_sat=0, data passes unchanged.
- Queue is a circular FIFO with wr_ptr, rd_ptr and count (width clog2(QueueDepth)+1). Pointers wrap modulo QueueDepth.
- Enqueue when accepted and (count<QueueDepth or a commit occurs in the same cycle).
- An accepted bundle arriving with count==QueueDepth and no commit that cycle is dropped and sets ovf_err.
- Commit: rf_req & rf_grant in the same cycle. Head entry is popped.
- FSM has two states:
  - IDLE: rf_req=0. Go to REQ when count becomes non-zero.
  - REQ: rf_req=1, payload held stable from head. On grant: stay in REQ if the queue is still non-empty after the pop (next entry presented the following cycle), else go to IDLE.
- rf_grant is ignored while rf_req=0.
- Sticky flags:
  - sticky_flags |= OR of in_flagsN over lanes with in_maskN=1, for enqueued bundles only.
  - flags_clr clears the register. If flags_clr and an enqueue occur in the same cycle, the result equals the new bundle's flags.
  - sclr does not affect sticky_flags.
- sclr has priority over enqueue and commit. It empties the queue, returns to IDLE, and clears ovf_err. A grant in the sclr cycle is not a commit.
- ovf_err is cleared only by sclr or reset.

## Timing
- Reset values: rf_req=0, rf_bank_we=0, rf_addr=0, rf_lane_we=0, rf_data*=0, in_full=0, busy=0, sticky_flags=0, ovf_err=0, FSM=IDLE, pointers/count=0.
- All outputs are registered or decoded from registered state; there is no combinational input→output path.
- Latency: a bundle enqueued at edge N into an empty queue gives rf_req=1 with its payload after edge N. The earliest commit is cycle N+1.
- Throughput: one commit per cycle when rf_grant is held high.
- rf_req stays high and the payload stays stable until grant. Payload changes only on the edge following a commit.
- in_full reflects count after the current edge's enqueue and commit.
- Simultaneous enqueue and commit at full: count is unchanged, in_full stays 1, no drop.
- Asynchronous reset mid-request: rf_req falls immediately. The bundle is lost by design.

## Structure
- Shared package gpu_wb_pkg holds the flag bit indices (NV=4..NX=0), the constants SAT_ONE=32'h3F800000 and SAT_ZERO=32'h0, and the FSM state encoding (IDLE=1'b0, REQ=1'b1).
- One sub-module: wb_saturate, a combinational single-lane clamp instantiated four times.
- The queue is implemented inline, as register arrays indexed by pointer.

## Test plan
- Reset, then a single bundle (mask=4'b1111, bank_we=8'h01, addr=5'd3, in_sat=0), with rf_grant tied to 1 → rf_req high one cycle after accept, rf_data equals inputs, busy falls two cycles after accept.
- Saturate: in_sat=1 with lanes 0xBF800000, 0x7FC00000, 0x40000000, 0x3F000000 → rf_data 0x0, 0x0, 0x3F800000, 0x3F000000.
- Backpressure: rf_grant=0 and three back-to-back accepted bundles → first two queued, in_full=1 after the second, third dropped, ovf_err=1. Raising grant then commits the two in order.
- Full with simultaneous commit: queue full, grant=1, new bundle accepted → no drop, in_full stays 1, three total commits in order.
- Flags: lane1 flags=5'b00100, lane2 flags=5'b00001, mask=4'b0010 → sticky_flags=5'b00100. flags_clr in the same cycle as a bundle with lane0 flags 5'b10000 → sticky_flags=5'b10000.
- sclr while in REQ with rf_grant=1 in the same cycle → no commit, busy=0 and rf_req=0 the next cycle, sticky_flags retained, ovf_err cleared.
